fir_mac_l: RTL and testbench

Time-multiplexed 64-tap FIR engine that sits directly upstream of the left-channel coefficient ROM (`h_rom_l`). It drives the ROM address and tone-select inputs and consumes the 16-bit signed Q15 coefficient the ROM returns in the same cycle. Each accepted input sample is stored in a 64-entry circular delay line. The block then performs a 64-cycle serial multiply-accumulate and delivers one rounded 16-bit output sample.

---
 rtl/fir_mac_l_if.sv | 37 +++
 rtl/fir_mac_l.sv | 167 ++++++++++++++++
 tb/tb_fir_mac_l.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fir_mac_l_if.sv
// -----------------------------------------------------------------------------
// fir_mac_l_if
// Purpose : groups the sample stream, the coefficient ROM bus and the filtered
//           output of fir_mac_l into one bundle.
// Signals : sample_in/sample_valid/sample_ready - input sample handshake
//           rising_tone                          - coefficient-set request
//           coef_sel/coef_addr/coef_data         - coefficient ROM bus
//           dout/dout_valid                      - filtered output sample
//           overrun                              - dropped-sample pulse
// Modports: slave  - the FIR engine
//           master - the surrounding system (sample source, ROM, sink)
// -----------------------------------------------------------------------------
interface fir_mac_l_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
);
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              sample_ready;
  logic              rising_tone;
  logic              coef_sel;
  logic [ADDR_W-1:0] coef_addr;
  logic [DATA_W-1:0] coef_data;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              overrun;

  modport slave (
    input  sample_in, sample_valid, rising_tone, coef_data,
    output sample_ready, coef_sel, coef_addr, dout, dout_valid, overrun
  );

  modport master (
    output sample_in, sample_valid, rising_tone, coef_data,
    input  sample_ready, coef_sel, coef_addr, dout, dout_valid, overrun
  );
endinterface

// File: rtl/fir_mac_l.sv
// -----------------------------------------------------------------------------
// fir_mac_l
// Purpose : time-multiplexed 64-tap FIR engine feeding the left-channel
//           coefficient ROM. Each accepted sample goes into a circular delay
//           line, then 64 serial multiply-accumulate cycles produce one
//           rounded Q15 output sample.
// Ports   : clk    - rising-edge clock
//           rst    - asynchronous active-high reset
//           io_bus - fir_mac_l_if.slave (sample handshake, ROM bus, output)
// Config  : FIR_SAT_EN - when defined, the rounded output saturates to
//           16'h7FFF / 16'h8000; otherwise it wraps.
// -----------------------------------------------------------------------------
module fir_mac_l #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int ACC_W  = 2*DATA_W + ADDR_W
) (
  input  logic       clk,
  input  logic       rst,
  fir_mac_l_if.slave io_bus
);
  localparam int TAPS   = 1 << ADDR_W;
  localparam int PROD_W = 2*DATA_W;
  // Half an output LSB (2^14 for Q15) used for round-half-up.
  localparam logic signed [ACC_W-1:0] RND_HALF = {{(ACC_W-1){1'b0}}, 1'b1} << (DATA_W-2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic signed [DATA_W-1:0] r_buf [TAPS];
  logic [ADDR_W-1:0]        r_wr_ptr;
  logic [ADDR_W-1:0]        r_tap;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_coef_sel;
  logic [DATA_W-1:0]        r_dout;
  logic                     r_dout_valid;
  logic                     r_overrun;

  logic                     w_busy;
  logic                     w_last_tap;
  logic [ADDR_W-1:0]        w_rd_idx;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic [DATA_W-1:0]        w_dout_nxt;

  assign w_busy     = (r_state != ST_IDLE);
  assign w_last_tap = (r_tap == {ADDR_W{1'b1}});
  // r_wr_ptr points at the newest sample; tap t reaches t samples back.
  assign w_rd_idx   = r_wr_ptr - r_tap;
  assign w_prod     = r_buf[w_rd_idx] * $signed(io_bus.coef_data);
  assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

`ifdef FIR_SAT_EN
  // Rounded accumulator shifted down by 15; the top bits tell whether the
  // result fits in DATA_W bits.
  logic signed [ACC_W-DATA_W:0] w_q;
  logic                         w_fits;
  assign w_q    = (ACC_W-DATA_W+1)'((r_acc + RND_HALF) >>> (DATA_W-1));
  assign w_fits = (&w_q[ACC_W-DATA_W:DATA_W-1]) | ~(|w_q[ACC_W-DATA_W:DATA_W-1]);

  // Output clamp: pass through when representable, else saturate by sign.
  always_comb begin
    w_dout_nxt = w_q[DATA_W-1:0];
    if (w_fits) begin
      w_dout_nxt = w_q[DATA_W-1:0];
    end else if (w_q[ACC_W-DATA_W]) begin
      w_dout_nxt = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      w_dout_nxt = {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  // Output rounding without clamp: bits [30:15] of acc + 2^14, wrapping.
  always_comb begin
    w_dout_nxt = DATA_W'((r_acc + RND_HALF) >>> (DATA_W-1));
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (io_bus.sample_valid) begin
          w_state_nxt = ST_MAC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MAC: begin
        if (w_last_tap) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_MAC;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: delay line, accumulator, tap counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        r_buf[i] <= {DATA_W{1'b0}};
      end
      r_wr_ptr     <= {ADDR_W{1'b0}};
      r_tap        <= {ADDR_W{1'b0}};
      r_acc        <= {ACC_W{1'b0}};
      r_coef_sel   <= 1'b0;
      r_dout       <= {DATA_W{1'b0}};
      r_dout_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      // Any sample offered while busy is dropped and flagged.
      r_overrun    <= w_busy & io_bus.sample_valid;
      case (r_state)
        ST_IDLE: begin
          if (io_bus.sample_valid) begin
            r_buf[r_wr_ptr] <= io_bus.sample_in;
            r_coef_sel      <= io_bus.rising_tone;
            r_acc           <= {ACC_W{1'b0}};
            r_tap           <= {ADDR_W{1'b0}};
          end
        end
        ST_MAC: begin
          r_acc <= r_acc + w_prod_ext;
          r_tap <= r_tap + {{(ADDR_W-1){1'b0}}, 1'b1};
          // The next sample lands in the following slot.
          if (w_last_tap) begin
            r_wr_ptr <= r_wr_ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          r_dout       <= w_dout_nxt;
          r_dout_valid <= 1'b1;
        end
        default: begin
          r_dout_valid <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.sample_ready = (r_state == ST_IDLE);
  assign io_bus.coef_sel     = r_coef_sel;
  assign io_bus.coef_addr    = (r_state == ST_MAC) ? r_tap : {ADDR_W{1'b0}};
  assign io_bus.dout         = r_dout;
  assign io_bus.dout_valid   = r_dout_valid;
  assign io_bus.overrun      = r_overrun;
endmodule

// File: tb/tb_fir_mac_l.sv
// -----------------------------------------------------------------------------
// tb_fir_mac_l
// Purpose : self-checking bench for fir_mac_l. Provides a combinational model
//           of the coefficient ROM, a convolution reference model over the
//           history of accepted samples, an impulse vector table, and
//           directed sequences for tone latching, overrun, saturation,
//           mid-computation reset and back-to-back random streaming.
//           Honours FIR_SAT_EN in its expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fir_mac_l;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_mac_l_if #(.DATA_W(16), .ADDR_W(6)) bus ();

  fir_mac_l #(.DATA_W(16), .ADDR_W(6), .ACC_W(38)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  // Coefficient ROM stand-in: rising and falling sets, same-cycle read.
  logic signed [15:0] rom_r [64];
  logic signed [15:0] rom_f [64];
  assign bus.coef_data = bus.coef_sel ? rom_r[bus.coef_addr] : rom_f[bus.coef_addr];

  int n_vec = 0;
  int n_mis = 0;

  typedef struct {
    logic [15:0] sample;
    logic        tone;
    logic [15:0] exp;
  } vec_t;
  vec_t imp_tbl [64];

  // History of accepted samples, oldest first (at most 64 kept).
  logic signed [15:0] m_q [$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: y = sum_t x[n-t]*h[t], round half up at bit 15, clamp or wrap.
  function automatic logic [15:0] model_out(input logic tone);
    longint acc;
    acc = 0;
    for (int t = 0; t < 64; t++) begin
      if (t < m_q.size()) begin
        acc += longint'(m_q[m_q.size()-1-t]) * longint'(tone ? rom_r[t] : rom_f[t]);
      end
    end
    acc = (acc + 64'sd16384) >>> 15;
`ifdef FIR_SAT_EN
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
`endif
    return acc[15:0];
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, bus.sample_ready, 1);
    chk({tag, "_dout"}, bus.dout, 0);
    chk({tag, "_dvalid"}, bus.dout_valid, 0);
    chk({tag, "_overrun"}, bus.overrun, 0);
    chk({tag, "_coef_sel"}, bus.coef_sel, 0);
    chk({tag, "_coef_addr"}, bus.coef_addr, 0);
  endtask

  // Offer one sample when ready, then follow the computation cycle by cycle.
  // tog_at: flip rising_tone k cycles after acceptance; ova/ovb: offer a
  // stray sample on edge E<ova>/E<ovb>; rst_at: assert reset at edge E<rst_at>.
  task automatic send(input logic [15:0] s, input logic tone, input int tog_at,
                      input int ova, input int ovb, input int rst_at,
                      output logic [15:0] y, output bit got);
    int k;
    int n_ovr;
    int exp_ovr;
    bit ctl_bad;
    k = 0; got = 1'b0; y = 16'h0000; n_ovr = 0; ctl_bad = 1'b0; exp_ovr = 0;
    while (!bus.sample_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("ready_before_send", bus.sample_ready, 1);
    bus.sample_in    = s;
    bus.sample_valid = 1'b1;
    bus.rising_tone  = tone;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    m_q.push_back(s);
    if (m_q.size() > 64) void'(m_q.pop_front());
    k = 0;
    while (!got && k < 100) begin
      if (bus.dout_valid) begin
        got = 1'b1;
        y   = bus.dout;
      end else begin
        if (rst_at < 0) begin
          if (bus.coef_sel !== tone) ctl_bad = 1'b1;
          if (bus.sample_ready !== 1'b0) ctl_bad = 1'b1;
          if (k < 64 && bus.coef_addr !== k[5:0]) ctl_bad = 1'b1;
          if (k >= 64 && bus.coef_addr !== 6'd0) ctl_bad = 1'b1;
        end
        if (k == tog_at) bus.rising_tone = ~tone;
        if (k == ova-1 || k == ovb-1) begin
          bus.sample_valid = 1'b1;
          bus.sample_in    = 16'h7ABC;
        end else begin
          bus.sample_valid = 1'b0;
        end
        if (k == rst_at-1) begin
          @(posedge clk);
          #1 rst = 1'b1;
          #1 chk_reset_outputs("midrst");
        end
        @(negedge clk);
        k++;
        if (bus.overrun) n_ovr++;
      end
    end
    bus.sample_valid = 1'b0;
    if (rst_at < 0) begin
      if (ova > 0) exp_ovr++;
      if (ovb > 0) exp_ovr++;
      chk("dout_valid_seen", got, 1);
      chk("latency", k, 65);
      chk("ctrl_during_mac", ctl_bad, 0);
      chk("overrun_pulses", n_ovr, exp_ovr);
    end else begin
      chk("no_valid_after_rst", got, 0);
    end
  endtask

  task automatic run_impulse(input string tag);
    logic [15:0] y;
    bit got;
    int d;
    for (int n = 0; n < 64; n++) begin
      send(imp_tbl[n].sample, imp_tbl[n].tone, -1, -1, -1, -1, y, got);
      chk({tag, "_exact"}, y, imp_tbl[n].exp);
      d = int'($signed(y)) - int'(rom_r[n]);
      chk({tag, "_within_1lsb"}, (d >= -1 && d <= 1), 1);
      if (n == 0) chk({tag, "_first"}, y, 16'hFFE2);
    end
  endtask

  initial begin
    logic [15:0] y;
    logic [15:0] s;
    logic        tn;
    bit          got;
    int          v;
    int          p;
    int          q;

    // ROM contents: symmetric rising set, alternating-sign falling set.
    for (int n = 0; n < 32; n++) begin
      v = (n == 31) ? 23936 : n*n*24 - 30;
      rom_r[n]    = v[15:0];
      rom_r[63-n] = v[15:0];
    end
    for (int n = 0; n < 64; n++) begin
      v = 1000 + n*300;
      if (n % 2 == 1) v = -v;
      rom_f[n] = v[15:0];
    end
    // Impulse table: output n is round(32767 * h_rising[n] / 2^15).
    for (int n = 0; n < 64; n++) begin
      imp_tbl[n].sample = (n == 0) ? 16'h7FFF : 16'h0000;
      imp_tbl[n].tone   = 1'b1;
      p = 32767 * int'(rom_r[n]);
      q = (p + 16384) >>> 15;
      imp_tbl[n].exp    = q[15:0];
    end

    bus.sample_in    = 16'h0000;
    bus.sample_valid = 1'b0;
    bus.rising_tone  = 1'b0;
    rst              = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    run_impulse("impulse");

    // Tone latch: accept with tone 0, flip the request mid-computation.
    send($urandom, 1'b0, 10, -1, -1, -1, y, got);
    chk("tone_latch_dout", y, model_out(1'b0));

    // Overrun: stray samples at E5 and E20 must not reach the delay line.
    send($urandom, 1'b1, -1, 5, 20, -1, y, got);
    chk("overrun_dout", y, model_out(1'b1));
    send($urandom, 1'b1, -1, -1, -1, -1, y, got);
    chk("after_overrun_dout", y, model_out(1'b1));

    // Saturation: sample feeding tap 63-k gets the sign of that coefficient.
    for (int k = 0; k < 64; k++) begin
      s = (rom_f[63-k] >= 0) ? 16'h7FFF : 16'h8001;
      send(s, 1'b0, -1, -1, -1, -1, y, got);
      chk("sat_stream", y, model_out(1'b0));
    end
`ifdef FIR_SAT_EN
    chk("sat_clamp", y, 16'h7FFF);
`endif

    // Reset at E30 aborts the computation and clears the delay line.
    send($urandom, 1'b1, -1, -1, -1, 30, y, got);
    @(negedge clk);
    rst = 1'b0;
    m_q.delete();
    repeat (2) @(negedge clk);
    run_impulse("impulse_after_rst");

    // Back-to-back random stream across the write-pointer wrap.
    for (int i = 0; i < 130; i++) begin
      s  = 16'($urandom);
      tn = 1'($urandom_range(0, 1));
      send(s, tn, -1, -1, -1, -1, y, got);
      chk("random_stream", y, model_out(tn));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
